// File: rtl/jtag_drv_pkg.sv
// Shared types and constants for the simulation-side JTAG initiator.
package jtag_drv_pkg;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_IDLE,
    ST_RTI,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE,
    ST_RESP
  } drv_state_e;

  localparam int TLR_CYCLES = 5;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: tck toggles every TCK_DIV clk while enabled; rise/fall strobes
// mark the clk edge on which tck changes. Disabled -> tck held 0, counter cleared.
module jtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = $clog2(TCK_DIV);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == CW'(TCK_DIV - 1));
  assign tck_rise = wrap && !tck;
  assign tck_fall = wrap && tck;

  // half-period counter and tck level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_tap_driver.sv
// JTAG initiator: walks the 1149.1 TAP for IR/DR scans issued over valid/ready.
// Optional build macro JTAG_TAP_DRIVER_TRACE_EN adds $display tracing only.
module jtag_tap_driver #(
  parameter int TCK_DIV = 4,
  parameter int MAX_LEN = 64,
  parameter int IR_LEN  = 5,
  parameter int LEN_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

  import jtag_drv_pkg::*;

  drv_state_e         state;
  logic [2:0]         tlr_cnt;
  logic               is_ir;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] data;
  logic [MAX_LEN-1:0] mask;
  logic               tck_en;
  logic               tck_rise;
  logic               tck_fall;

  assign tck_en = (state != ST_IDLE) && (state != ST_RESP);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (tck_en),
    .tck      (jtag_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  // scan length after IR override and clamping to the data width
  always_comb begin
    eff_len = cmd_len;
    if (cmd_is_ir) begin
      eff_len = LEN_W'(IR_LEN);
    end else if (cmd_len > LEN_W'(MAX_LEN)) begin
      eff_len = LEN_W'(MAX_LEN);
    end else begin
      eff_len = cmd_len;
    end
  end

  // TAP walk: the state names the TCK cycle in progress; TMS/TDI for the
  // next cycle are set on each fall, TDO is sampled on each rise in SHIFT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_TLR;
      tlr_cnt   <= 3'd0;
      is_ir     <= 1'b0;
      len       <= '0;
      bit_cnt   <= '0;
      data      <= '0;
      mask      <= '0;
      jtag_tms  <= 1'b1;
      jtag_tdi  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ST_TLR: if (tck_fall) begin
          if (tlr_cnt == 3'(TLR_CYCLES)) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            tlr_cnt  <= tlr_cnt + 3'd1;
            jtag_tms <= (tlr_cnt < 3'(TLR_CYCLES - 1));
          end
        end
        ST_IDLE: if (cmd_valid && cmd_ready) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          is_ir     <= cmd_is_ir;
          len       <= eff_len;
          data      <= cmd_data;
          mask      <= MAX_LEN'(1);
          bit_cnt   <= '0;
          rsp_data  <= '0;
          // an empty DR scan never touches the TAP
          if (!cmd_is_ir && eff_len == '0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
          end else begin
            state    <= ST_RTI;
            jtag_tms <= 1'b1;
          end
        end
        ST_RTI: if (tck_fall) begin
          state    <= ST_SEL_DR;
          jtag_tms <= is_ir;
        end
        ST_SEL_DR: if (tck_fall) begin
          state    <= is_ir ? ST_SEL_IR : ST_CAPTURE;
          jtag_tms <= 1'b0;
        end
        ST_SEL_IR: if (tck_fall) begin
          state    <= ST_CAPTURE;
          jtag_tms <= 1'b0;
        end
        ST_CAPTURE: if (tck_fall) begin
          state    <= ST_SHIFT;
          jtag_tms <= (len == LEN_W'(1));
          jtag_tdi <= data[0];
          data     <= data >> 1;
        end
        ST_SHIFT: begin
          if (tck_rise) begin
            rsp_data <= rsp_data | (jtag_tdo ? mask : '0);
            mask     <= mask << 1;
          end
          if (tck_fall) begin
            if (bit_cnt + LEN_W'(1) == len) begin
              state    <= ST_EXIT1;
              jtag_tms <= 1'b1;
              jtag_tdi <= 1'b0;
            end else begin
              bit_cnt  <= bit_cnt + LEN_W'(1);
              jtag_tms <= (bit_cnt + LEN_W'(2) == len);
              jtag_tdi <= data[0];
              data     <= data >> 1;
            end
          end
        end
        ST_EXIT1: if (tck_fall) begin
          state    <= ST_UPDATE;
          jtag_tms <= 1'b0;
        end
        ST_UPDATE: if (tck_fall) begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
        end
        ST_RESP: if (rsp_ready) begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state    <= ST_TLR;
          tlr_cnt  <= 3'd0;
          jtag_tms <= 1'b1;
          busy     <= 1'b1;
        end
      endcase
    end
  end

`ifdef JTAG_TAP_DRIVER_TRACE_EN
  logic [MAX_LEN-1:0] trace_tdi;

  // scan and TAP-reset trace messages
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cmd_valid && cmd_ready) trace_tdi <= cmd_data;
    if (state == ST_RESP && rsp_ready)
      $display("%0t jtag_tap_driver %s len=%0d tdi=%h tdo=%h", $time,
               is_ir ? "IR" : "DR", len, trace_tdi, rsp_data);
    if (state == ST_TLR && tck_fall && tlr_cnt == 3'd0)
      $display("%0t jtag_tap_driver TAP reset", $time);
  end
`endif

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: a behavioural TAP (BYPASS DR, IR captures 00001)
// answers the pins; directed scan vectors plus reset corner sequences.
module tb_jtag_tap_driver;
  import jtag_drv_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_is_ir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               jtag_tck, jtag_tms, jtag_tdi;
  logic               tdo_m = 1'b0;

  jtag_tap_driver #(.TCK_DIV(4), .MAX_LEN(MAX_LEN), .IR_LEN(5), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(tdo_m)
  );

  always #5 clk = ~clk;

  // Behavioural 1149.1 TAP
  typedef enum logic [3:0] {T_TLR, T_RTI, T_SDS, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR,
                            T_UDR, T_SIS, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_e;
  tap_e       tap = T_TLR;
  logic       dr_sr = 1'b0;
  logic [4:0] ir_sr = 5'd0;
  logic [4:0] ir = 5'd0;
  int         rises = 0, shift_n = 0, exit_at = 0;
  logic [7:0] tms_log = 8'd0;
  longint     last_rise = 0, rise_period = 0, last_fall = 0;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDS  : T_RTI;
      T_SDS:  return m ? T_SIS  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDS  : T_RTI;
      T_SIS:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      T_UIR:  return m ? T_SDS  : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    rises       <= rises + 1;
    tms_log     <= {tms_log[6:0], jtag_tms};
    rise_period <= $time - last_rise;
    last_rise   <= $time;
    case (tap)
      T_CDR: dr_sr <= 1'b0;
      T_CIR: ir_sr <= 5'b00001;
      T_SHDR: begin
        dr_sr   <= jtag_tdi;
        shift_n <= shift_n + 1;
        if (jtag_tms) exit_at <= shift_n + 1;
      end
      T_SHIR: begin
        ir_sr   <= {jtag_tdi, ir_sr[4:1]};
        shift_n <= shift_n + 1;
        if (jtag_tms) exit_at <= shift_n + 1;
      end
      T_UIR: ir <= ir_sr;
      default: ;
    endcase
    tap <= tap_next(tap, jtag_tms);
  end

  always @(negedge jtag_tck) begin
    last_fall <= $time;
    tdo_m <= (tap == T_SHDR) ? dr_sr : (tap == T_SHIR) ? ir_sr[0] : 1'b0;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             is_ir;
    logic [LEN_W-1:0] len;
    logic [63:0]      data;
    logic [63:0]      exp_rsp;
    int               exp_rises;
    int               exp_shift;
    logic [4:0]       exp_ir;
    int               hold;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, cmd_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    logic stable;
    wait_ready(tag);
    rises = 0; shift_n = 0; exit_at = 0;
    cmd_valid = 1'b1; cmd_is_ir = v.is_ir; cmd_len = v.len; cmd_data = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(v.exp_rises * 8 + 1));
    check({tag, "_rsp_data"}, rsp_data, v.exp_rsp);
    check({tag, "_tck_rises"}, 64'(rises), 64'(v.exp_rises));
    check({tag, "_shift_bits"}, 64'(shift_n), 64'(v.exp_shift));
    check({tag, "_tms_exit_bit"}, 64'(exit_at), 64'(v.exp_shift));
    check({tag, "_tap_in_rti"}, 64'(tap), 64'(T_RTI));
    if (v.is_ir) check({tag, "_ir_reg"}, 64'(ir), 64'(v.exp_ir));
    stable = 1'b1;
    repeat (v.hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== v.exp_rsp || cmd_ready || jtag_tck || !busy) stable = 1'b0;
    end
    check({tag, "_resp_hold"}, 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_release"}, {rsp_valid, cmd_ready, busy}, 3'b010);
  endtask

  task automatic check_tlr(input string tag);
    wait_ready(tag);
    check({tag, "_tlr_rises"}, 64'(rises), 64'd6);
    check({tag, "_tlr_tms"}, 64'(tms_log[5:0]), 64'b111110);
    check({tag, "_tck_period"}, 64'(rise_period), 64'd80);
    check({tag, "_ready_after_fall"}, 64'($time - last_fall), 64'd5);
    check({tag, "_tap_in_rti"}, 64'(tap), 64'(T_RTI));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_rsp;
    int n;
    //           is_ir len     data                    exp_rsp                 rises shift ir         hold
    vecs[0] = '{1'b1, 7'd0,   64'(IR_IDCODE),         64'h01,                 11,   5,    IR_IDCODE, 4};
    vecs[1] = '{1'b0, 7'd8,   64'hA5,                 64'h4A,                 13,   8,    5'd0,      20};
    vecs[2] = '{1'b0, 7'd0,   64'hFF,                 64'h0,                  0,    0,    5'd0,      3};
    vecs[3] = '{1'b0, 7'd100, 64'hF0F0_1234_5678_9ABC, 64'hE1E0_2468_ACF1_3578, 69,   64,   5'd0,      3};
    vecs[4] = '{1'b1, 7'd9,   64'(IR_DMI),            64'h01,                 11,   5,    IR_DMI,    3};
    vecs[5] = '{1'b0, 7'd3,   64'hFFFF_FFFF_FFFF_FFF5, 64'h2,                  8,    3,    5'd0,      3};
    vecs[6] = '{1'b0, 7'd1,   64'h1,                  64'h0,                  6,    1,    5'd0,      3};
    vecs[7] = '{1'b1, 7'd0,   64'(IR_DTMCS),          64'h01,                 11,   5,    IR_DTMCS,  3};

    repeat (3) @(negedge clk);
    check("reset_pins", {jtag_tck, jtag_tms, jtag_tdi, cmd_ready, rsp_valid, busy}, 6'b010001);
    check("reset_rsp_data", rsp_data, 64'h0);
    rises = 0; tms_log = 8'd0;
    rst = 1'b0;
    check_tlr("init");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a 32-bit DR scan
    wait_ready("midrst");
    rises = 0; shift_n = 0; exit_at = 0;
    cmd_valid = 1'b1; cmd_is_ir = 1'b0; cmd_len = 7'd32; cmd_data = 64'hDEAD_BEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (shift_n < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_bit3", 64'(shift_n), 64'd3);
    rst = 1'b1;
    #1;
    check("midrst_pins", {jtag_tck, jtag_tms, jtag_tdi, cmd_ready, rsp_valid, busy}, 6'b010001);
    check("midrst_rsp_data", rsp_data, 64'h0);
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    rises = 0; tms_log = 8'd0;
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
      n++;
    end
    check("midrst_no_rsp", 64'(saw_rsp), 64'd0);
    check_tlr("midrst");
    run_vec(vecs[0], "post_rst_ir");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
